// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: steps each instruction through fetch/decode/execute/memory/writeback
// and decodes datapath selects and write enables from the current state (pcen also uses zero).
module mips_multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       immzext,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    BNEEX   = 4'd9,
    IMMEX   = 4'd10,
    IMMWB   = 4'd11,
    JEX     = 4'd12,
    UNUSED13 = 4'd13,
    UNUSED14 = 4'd14,
    UNUSED15 = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_BAD = 3'd3;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  // Unknown funct yields ALU_BAD, which also steers RTYPEEX back to FETCH.
  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: rtype_alu = ALU_ADD;
      6'b100010: rtype_alu = ALU_SUB;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b101010: rtype_alu = ALU_SLT;
      default:   rtype_alu = ALU_BAD;
    endcase
  endfunction

  function automatic logic [2:0] imm_alu(input logic [5:0] o);
    case (o)
      OP_ANDI: imm_alu = ALU_AND;
      OP_ORI:  imm_alu = ALU_OR;
      OP_SLTI: imm_alu = ALU_SLT;
      default: imm_alu = ALU_ADD;
    endcase
  endfunction

  function automatic logic imm_zext(input logic [5:0] o);
    imm_zext = (o == OP_ANDI) || (o == OP_ORI);
  endfunction

  state_t cur_state, nxt_state;
  logic   memwrite_d, irwrite_d, regwrite_d, pcen_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur_state <= state_t'(RESET_STATE);
    else          cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state  = FETCH;
    iord       = 1'b0;
    memwrite_d = 1'b0;
    irwrite_d  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_d = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    immzext    = 1'b0;
    pcsrc      = 2'b00;
    pcen_d     = 1'b0;
    alucontrol = ALU_AND;
    case (cur_state)
      FETCH: begin
        irwrite_d  = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        pcen_d     = 1'b1;
        nxt_state  = DECODE;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        case (op)
          OP_LW, OP_SW:                       nxt_state = MEMADR;
          OP_RTYPE:                           nxt_state = RTYPEEX;
          OP_BEQ:                             nxt_state = BEQEX;
          OP_BNE:                             nxt_state = BNEEX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  nxt_state = IMMEX;
          OP_J:                               nxt_state = JEX;
          default:                            nxt_state = FETCH;
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        nxt_state  = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord      = 1'b1;
        nxt_state = MEMWB;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_d = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_d = 1'b1;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu(funct);
        nxt_state  = (rtype_alu(funct) == ALU_BAD) ? FETCH : RTYPEWB;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_d = 1'b1;
        alucontrol = rtype_alu(funct);
      end
      BEQEX, BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen_d     = (cur_state == BEQEX) ? zero : ~zero;
      end
      IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = imm_alu(op);
        immzext    = imm_zext(op);
        nxt_state  = IMMWB;
      end
      IMMWB: begin
        regwrite_d = 1'b1;
        alucontrol = imm_alu(op);
        immzext    = imm_zext(op);
      end
      JEX: begin
        pcsrc  = 2'b10;
        pcen_d = 1'b1;
      end
      default: nxt_state = FETCH;
    endcase
  end

  // Enables are gated by reset_n directly so none can pulse while reset is asserted.
  assign memwrite = memwrite_d & reset_n;
  assign irwrite  = irwrite_d  & reset_n;
  assign regwrite = regwrite_d & reset_n;
  assign pcen     = pcen_d     & reset_n;
  assign state    = cur_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: expected per-cycle state/outputs queued at issue, compared mid-cycle.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, immzext, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .immzext(immzext), .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [15:0] outs;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  logic [15:0] dut_outs;
  assign dut_outs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                     alusrcb, immzext, pcsrc, pcen, alucontrol};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [2:0] ref_rfun(input logic [5:0] f);
    logic [2:0] r;
    r = 3'd3;
    if (f == 6'h20) r = 3'd2;
    if (f == 6'h22) r = 3'd6;
    if (f == 6'h24) r = 3'd0;
    if (f == 6'h25) r = 3'd1;
    if (f == 6'h2a) r = 3'd7;
    return r;
  endfunction

  // Expected decode, built field by field from the state table.
  function automatic logic [15:0] ref_outs(input logic [3:0] s, input logic [5:0] o,
                                           input logic [5:0] f, input logic z);
    logic e_iord, e_mw, e_irw, e_rd, e_mtr, e_rw, e_asa, e_imz, e_pcen;
    logic [1:0] e_asb, e_pcsrc;
    logic [2:0] e_alu;
    {e_iord, e_mw, e_irw, e_rd, e_mtr, e_rw, e_asa, e_imz, e_pcen} = '0;
    e_asb = 2'b00; e_pcsrc = 2'b00; e_alu = 3'd0;
    if (s == 4'd0)  begin e_irw = 1; e_asb = 2'b01; e_alu = 3'd2; e_pcen = 1; end
    if (s == 4'd1)  begin e_asb = 2'b11; e_alu = 3'd2; end
    if (s == 4'd2)  begin e_asa = 1; e_asb = 2'b10; e_alu = 3'd2; end
    if (s == 4'd3)  e_iord = 1;
    if (s == 4'd4)  begin e_mtr = 1; e_rw = 1; end
    if (s == 4'd5)  begin e_iord = 1; e_mw = 1; end
    if (s == 4'd6)  begin e_asa = 1; e_alu = ref_rfun(f); end
    if (s == 4'd7)  begin e_rd = 1; e_rw = 1; e_alu = ref_rfun(f); end
    if (s == 4'd8 || s == 4'd9) begin
      e_asa = 1; e_alu = 3'd6; e_pcsrc = 2'b01;
      e_pcen = (s == 4'd8) ? z : !z;
    end
    if (s == 4'd10 || s == 4'd11) begin
      if (s == 4'd10) begin e_asa = 1; e_asb = 2'b10; end
      else e_rw = 1;
      case (o)
        6'b001000: begin e_alu = 3'd2; e_imz = 0; end
        6'b001100: begin e_alu = 3'd0; e_imz = 1; end
        6'b001101: begin e_alu = 3'd1; e_imz = 1; end
        default:   begin e_alu = 3'd7; e_imz = 0; end
      endcase
    end
    if (s == 4'd12) begin e_pcsrc = 2'b10; e_pcen = 1; end
    return {e_iord, e_mw, e_irw, e_rd, e_mtr, e_rw, e_asa, e_asb, e_imz, e_pcsrc, e_pcen, e_alu};
  endfunction

  // Monitor: one expected entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "/state"}, {28'd0, state}, {28'd0, e.st});
      chk({e.tag, "/outs"}, {16'd0, dut_outs}, {16'd0, e.outs});
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    #2;
  endtask

  // Called at posedge+2 with DUT in FETCH; seq lists n states as hex nibbles, first one leftmost.
  task automatic run(input string tag, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input int n, input logic [31:0] seq);
    exp_t e;
    op = o; funct = f; zero = z;
    for (int k = 0; k < n; k++) begin
      e.tag  = tag;
      e.st   = seq[4*(n-1-k) +: 4];
      e.outs = ref_outs(e.st, o, f, z);
      sb.push_back(e);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; op = 6'b100011; funct = 6'h00; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/state", state, 0);
    chk("rst/enables", {pcen, irwrite, memwrite, regwrite}, 4'b0000);
    chk("rst/fetch_sel", {alusrcb, alucontrol}, {2'b01, 3'd2});
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #2;

    // After reset the first edge already left FETCH; resynchronise on the next FETCH.
    chk("rst/first_edge", state, 1);
    op = 6'b111111;
    @(posedge clk); #2;

    run("lw",      6'b100011, 6'h00, 0, 5, 32'h01234);
    run("sw",      6'b101011, 6'h00, 0, 4, 32'h0125);
    run("add",     6'b000000, 6'h20, 0, 4, 32'h0167);
    run("sub",     6'b000000, 6'h22, 0, 4, 32'h0167);
    run("and",     6'b000000, 6'h24, 0, 4, 32'h0167);
    run("or",      6'b000000, 6'h25, 1, 4, 32'h0167);
    run("slt",     6'b000000, 6'h2a, 0, 4, 32'h0167);
    run("badfn",   6'b000000, 6'h3f, 0, 3, 32'h016);
    run("beq_z1",  6'b000100, 6'h00, 1, 3, 32'h018);
    run("beq_z0",  6'b000100, 6'h00, 0, 3, 32'h018);
    run("bne_z1",  6'b000101, 6'h00, 1, 3, 32'h019);
    run("bne_z0",  6'b000101, 6'h00, 0, 3, 32'h019);
    run("addi",    6'b001000, 6'h00, 0, 4, 32'h01ab);
    run("andi",    6'b001100, 6'h00, 0, 4, 32'h01ab);
    run("ori",     6'b001101, 6'h00, 0, 4, 32'h01ab);
    run("slti",    6'b001010, 6'h00, 0, 4, 32'h01ab);
    run("j",       6'b000010, 6'h00, 0, 3, 32'h01c);
    run("illegal", 6'b111111, 6'h3f, 0, 2, 32'h01);

    // lw aborted by reset while in MEMRD.
    run("lw_abort", 6'b100011, 6'h00, 0, 3, 32'h012);
    chk("abort/in_memrd", state, 3);
    reset_n = 1'b0;
    #1;
    chk("abort/state", state, 0);
    chk("abort/enables", {pcen, irwrite, memwrite, regwrite}, 4'b0000);
    @(posedge clk); #1;
    chk("abort/hold_state", state, 0);
    chk("abort/hold_enables", {pcen, irwrite, memwrite, regwrite}, 4'b0000);
    reset_n = 1'b1;
    @(posedge clk); #2;
    chk("abort/restart", state, 1);
    op = 6'b111111;
    @(posedge clk); #2;
    run("post_abort_sw", 6'b101011, 6'h00, 0, 4, 32'h0125);
    run("final_fetch",   6'b111111, 6'h00, 0, 1, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
